// File: rtl/time_setter_if.sv
// Minute/second load interface between the time setter (master) and the countdown (slave).
interface time_setter_if;
    logic [3:0] minute_out;
    logic [5:0] second_out;
    logic       changed;
    logic       load_valid;

    // load_valid is a one-cycle strobe with no ready; the slave samples
    // minute_out/second_out on that cycle and must always accept it.
    modport master (output minute_out, output second_out, output changed, output load_valid);
    modport slave  (input  minute_out, input  second_out, input  changed, input  load_valid);
endinterface

// File: rtl/time_setter.sv
// Front-panel minute/second entry with single-step and hold-to-repeat keys,
// plus a single load strobe per confirm press.
module time_setter #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int MAX_MIN      = 9,
    parameter int DEFAULT_MIN  = 2,
    parameter int DEFAULT_SEC  = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               lock,
    input  logic               key_min_up,
    input  logic               key_min_dn,
    input  logic               key_sec_up,
    input  logic               key_sec_dn,
    input  logic               confirm,
    time_setter_if.master      load_if,
    output logic [1:0]         dbg_state
);
    localparam int CW = 26;
    localparam logic [CW-1:0] DLY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LOAD = CW'(REPEAT_RATE - 1);
    localparam logic [3:0]    MAX_M     = 4'(MAX_MIN);

    typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      active_key;
    logic [3:0]      minute_q;
    logic [5:0]      second_q;
    logic            changed_q;
    logic            load_valid_q;
    logic            confirm_q;

    logic [3:0]      key;
    logic            one_hot;
    logic            do_step;
    logic [3:0]      min_nxt;
    logic [5:0]      sec_nxt;

    always_comb begin
        key     = {key_min_up, key_min_dn, key_sec_up, key_sec_dn};
        one_hot = (key != 4'd0) && ((key & (key - 4'd1)) == 4'd0);
        do_step = 1'b0;
        unique case (state)
            IDLE:    do_step = !lock && one_hot;
            DELAY,
            REPEAT:  do_step = !lock && (key == active_key) && (cnt == '0);
            default: do_step = 1'b0;
        endcase
        // Fields wrap independently; no carry between minutes and seconds.
        min_nxt = minute_q;
        sec_nxt = second_q;
        unique case (key)
            4'b1000: min_nxt = (minute_q == MAX_M)  ? 4'd0  : minute_q + 4'd1;
            4'b0100: min_nxt = (minute_q == 4'd0)   ? MAX_M : minute_q - 4'd1;
            4'b0010: sec_nxt = (second_q == 6'd59)  ? 6'd0  : second_q + 6'd1;
            4'b0001: sec_nxt = (second_q == 6'd0)   ? 6'd59 : second_q - 6'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= '0;
            active_key   <= 4'd0;
            minute_q     <= 4'(DEFAULT_MIN);
            second_q     <= 6'(DEFAULT_SEC);
            changed_q    <= 1'b0;
            load_valid_q <= 1'b0;
            confirm_q    <= 1'b1;
        end else begin
            confirm_q    <= confirm;
            load_valid_q <= confirm && !confirm_q && !lock;
            changed_q    <= do_step;
            if (do_step) begin
                minute_q <= min_nxt;
                second_q <= sec_nxt;
            end
            if (lock) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: if (one_hot) begin
                        active_key <= key;
                        cnt        <= DLY_LOAD;
                        state      <= DELAY;
                    end
                    DELAY, REPEAT: begin
                        if (key != active_key) begin
                            state <= IDLE;
                        end else if (cnt == '0) begin
                            cnt   <= RATE_LOAD;
                            state <= REPEAT;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign load_if.minute_out = minute_q;
    assign load_if.second_out = second_q;
    assign load_if.changed    = changed_q;
    assign load_if.load_valid = load_valid_q;
    assign dbg_state          = state;
endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter with short repeat timing (delay 4, rate 2).
module tb_time_setter;
    logic clk;
    logic resetn;
    logic lock;
    logic key_min_up, key_min_dn, key_sec_up, key_sec_dn;
    logic confirm;
    logic [1:0] dbg_state;

    time_setter_if ts_if ();

    time_setter #(
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2),
        .MAX_MIN      (9),
        .DEFAULT_MIN  (2),
        .DEFAULT_SEC  (0)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .lock       (lock),
        .key_min_up (key_min_up),
        .key_min_dn (key_min_dn),
        .key_sec_up (key_sec_up),
        .key_sec_dn (key_sec_dn),
        .confirm    (confirm),
        .load_if    (ts_if),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the edge, outputs sampled there too
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tap(input int which);
        {key_min_up, key_min_dn, key_sec_up, key_sec_dn} = 4'(which);
        tick();
        {key_min_up, key_min_dn, key_sec_up, key_sec_dn} = 4'd0;
        tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    int chg_cnt;
    int lv_cnt;
    int exp_sec[9] = '{1, 1, 1, 1, 2, 2, 3, 3, 4};

    initial begin
        resetn = 1'b0; lock = 1'b0; confirm = 1'b0;
        {key_min_up, key_min_dn, key_sec_up, key_sec_dn} = 4'd0;
        #1;
        tick(); tick();
        check("rst_min", ts_if.minute_out, 2);
        check("rst_sec", ts_if.second_out, 0);
        check("rst_changed", ts_if.changed, 0);
        check("rst_load_valid", ts_if.load_valid, 0);
        check("rst_state", dbg_state, 0);
        resetn = 1'b1;
        tick();
        check("post_rst_min", ts_if.minute_out, 2);

        // auto-repeat: steps on edges 0, 4, 6, 8
        for (int v = 1; v <= 4; v++) exp_q.push_back(6'(v));
        key_sec_up = 1'b1;
        chg_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rep_sec", ts_if.second_out, exp_sec[i]);
            if (ts_if.changed) begin
                chg_cnt++;
                if (exp_q.size() == 0) check("rep_extra_step", 1, 0);
                else check("rep_changed_val", ts_if.second_out, exp_q.pop_front());
            end
        end
        check("rep_changed_count", chg_cnt, 4);
        check("rep_queue_empty", exp_q.size(), 0);
        key_sec_up = 1'b0;
        chg_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chg_cnt += ts_if.changed;
        end
        check("release_no_step", chg_cnt, 0);
        check("release_sec", ts_if.second_out, 4);

        // wrap
        do_reset();
        tap(1);
        check("wrap_sec_dn", ts_if.second_out, 59);
        tap(2);
        check("wrap_sec_up", ts_if.second_out, 0);
        check("wrap_sec_up_min", ts_if.minute_out, 2);
        tap(4); tap(4);
        check("min_dn_to_0", ts_if.minute_out, 0);
        tap(4);
        check("wrap_min_dn", ts_if.minute_out, 9);
        tap(8);
        check("wrap_min_up", ts_if.minute_out, 0);

        // two keys: no step, then dropping one is a fresh press
        key_sec_up = 1'b1; key_min_up = 1'b1;
        chg_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chg_cnt += ts_if.changed;
        end
        check("dual_no_changed", chg_cnt, 0);
        check("dual_sec", ts_if.second_out, 0);
        check("dual_min", ts_if.minute_out, 0);
        key_min_up = 1'b0;
        tick();
        check("drop_step_sec", ts_if.second_out, 1);
        check("drop_step_changed", ts_if.changed, 1);
        tick(); tick(); tick();
        check("drop_delay_hold", ts_if.second_out, 1);
        tick();
        check("drop_first_repeat", ts_if.second_out, 2);
        key_sec_up = 1'b0;
        tick(); tick();

        // lock
        lock = 1'b1; key_min_dn = 1'b1;
        chg_cnt = 0; lv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            confirm = (i == 3);
            tick();
            chg_cnt += ts_if.changed;
            lv_cnt  += ts_if.load_valid;
        end
        confirm = 1'b0;
        check("lock_no_changed", chg_cnt, 0);
        check("lock_no_load", lv_cnt, 0);
        check("lock_min_hold", ts_if.minute_out, 0);
        check("lock_state_idle", dbg_state, 0);
        lock = 1'b0;
        tick();
        check("unlock_step_min", ts_if.minute_out, 9);
        check("unlock_step_changed", ts_if.changed, 1);
        key_min_dn = 1'b0;
        tick(); tick();

        // confirm held yields one strobe
        confirm = 1'b1;
        lv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) check("confirm_first", ts_if.load_valid, 1);
            lv_cnt += ts_if.load_valid;
        end
        check("confirm_one_strobe", lv_cnt, 1);
        confirm = 1'b0;
        tick();

        // step and confirm on the same edge from 1:00
        do_reset();
        tap(4);
        check("pre_coinc_min", ts_if.minute_out, 1);
        key_sec_dn = 1'b1; confirm = 1'b1;
        tick();
        check("coinc_load_valid", ts_if.load_valid, 1);
        check("coinc_sec", ts_if.second_out, 59);
        check("coinc_min", ts_if.minute_out, 1);
        key_sec_dn = 1'b0; confirm = 1'b0;
        tick(); tick();

        // reset mid-hold with key and confirm held
        key_sec_up = 1'b1; confirm = 1'b1;
        tick(); tick();
        resetn = 1'b0;
        tick();
        check("midrst_sec", ts_if.second_out, 0);
        check("midrst_min", ts_if.minute_out, 2);
        check("midrst_changed", ts_if.changed, 0);
        resetn = 1'b1;
        tick();
        check("after_rst_step", ts_if.second_out, 1);
        check("after_rst_changed", ts_if.changed, 1);
        check("after_rst_no_load", ts_if.load_valid, 0);
        key_sec_up = 1'b0;
        lv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lv_cnt += ts_if.load_valid;
        end
        check("held_confirm_no_load", lv_cnt, 0);
        confirm = 1'b0;
        tick();
        confirm = 1'b1;
        tick();
        check("repress_load", ts_if.load_valid, 1);
        confirm = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/time_setter.md
Name: time_setter

Overview:
- Front-panel time-entry block; the writer side of the countdown timer's minute/second load interface.
- Converts four debounced key levels into a minute/second value with single-step and auto-repeat on hold.
- Emits a one-cycle load strobe when the player confirms. The countdown samples minute_out/second_out on that strobe.
- Sits between the board key debouncers and the countdown timer in the puzzle top level.

Parameters:
- REPEAT_DELAY, 25000000: hold cycles from the first step to the first auto-repeat step; legal range 1..2^26-1.
- REPEAT_RATE, 5000000: cycles between subsequent auto-repeat steps; legal range 1..2^26-1.
- MAX_MIN, 9: largest minute value; legal range 1..15.
- DEFAULT_MIN, 2: minute_out reset value; must be ≤ MAX_MIN.
- DEFAULT_SEC, 0: second_out reset value; must be ≤ 59.

Ports:
- clk  in  1  system clock, 50 MHz
- resetn  in  1  synchronous active-low reset
- lock  in  1  high while the countdown runs; freezes all editing
- key_min_up  in  1  debounced level, increment minutes
- key_min_dn  in  1  debounced level, decrement minutes
- key_sec_up  in  1  debounced level, increment seconds
- key_sec_dn  in  1  debounced level, decrement seconds
- confirm  in  1  debounced level, request load
- minute_out  out  4  current minute setting, 0..MAX_MIN
- second_out  out  6  current second setting, 0..59
- changed  out  1  one-cycle pulse after any step
- load_valid  out  1  one-cycle load strobe to the countdown

Behaviour:
- Interface: reset is resetn, synchronous, active-low; clock is clk. All outputs are registered; everything updates on posedge clk.
- Reset values:
  - minute_out=DEFAULT_MIN, second_out=DEFAULT_SEC.
  - changed=0, load_valid=0.
  - FSM=IDLE, repeat counter=0.
  - confirm history register=1, so a confirm held through reset does not fire.
- Key vector K = {min_up, min_dn, sec_up, sec_dn}. A "valid press" means K is exactly one-hot.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE:
    - If lock=0 and K is one-hot: apply the step for that key on this edge, latch K as the active key, load the counter with REPEAT_DELAY-1, go to DELAY.
    - Otherwise stay in IDLE.
  - DELAY:
    - If K differs from the active key: go to IDLE, no step.
    - Else if counter=0: apply the step, load the counter with REPEAT_RATE-1, go to REPEAT.
    - Else decrement the counter.
  - REPEAT:
    - If K differs from the active key: go to IDLE.
    - Else if counter=0: apply the step, reload REPEAT_RATE-1.
    - Else decrement.
- Step timing:
  - Resulting step edges: N (first sample with the key high), N+REPEAT_DELAY, then N+REPEAT_DELAY+k·REPEAT_RATE.
  - Switching directly from one single key to another: one edge in IDLE, then a fresh press on the following edge.
  - Zero, two or more keys high: no step; the FSM returns to or stays in IDLE.
- Step arithmetic (each field wraps independently, no carry or borrow between fields):
  - sec up: 59→0, else +1.
  - sec down: 0→59, else −1.
  - min up: MAX_MIN→0, else +1.
  - min down: 0→MAX_MIN, else −1.
- changed is 1 for exactly the cycle following each step edge, and 0 otherwise.
- lock:
  - While lock=1: the FSM is forced to IDLE on each edge, no steps occur, outputs hold, and confirm edges are ignored. The confirm history is still updated.
  - A key held across the fall of lock acts as a fresh press on the first edge with lock=0.
- Confirm:
  - load_valid=1 for one cycle after an edge where confirm=1, the history register=0, and lock=0.
  - A held confirm yields exactly one strobe.
  - If a step and a confirm fall on the same edge, load_valid is coincident with the updated value.
- Reset mid-hold: returns to the reset values immediately.
  - A key still held after resetn rises steps on the first edge after deassertion.
  - A held confirm does not strobe until it is released and pressed again.

Test Plan:
- Reset defaults: REPEAT_DELAY=4, REPEAT_RATE=2, DEFAULT 2:00. Pulse resetn → minute_out=2, second_out=0, changed=0, load_valid=0.
- Auto-repeat: from 2:00, hold key_sec_up 9 cycles.
  - second_out=1 after edge 0, 2 after edge 4, 3 after edge 6, 4 after edge 8.
  - changed pulses exactly 4 times.
  - Release → no further steps.
- Wrap: second_out=59, tap key_sec_up → 0 with minute unchanged. minute_out=0, tap key_min_dn → 9. minute_out=9, tap key_min_up → 0.
- Invalid combinations: assert key_sec_up and key_min_up together for 10 cycles → no change, changed stays 0.
  - Drop key_min_up while key_sec_up stays high → exactly one step on the next edge, then repeat timing restarts.
- lock: hold key_min_dn with lock=1 for 10 cycles → minute_out unchanged. Confirm pulse during lock → no load_valid.
  - Drop lock with the key still held → immediate step.
- Confirm: hold confirm for 5 cycles → load_valid high for exactly 1 cycle.
  - Press key_sec_dn and confirm on the same edge from 1:00 → load_valid coincides with second_out=59, minute_out=1.
